// File: rtl/radar_pkg.sv
// Shared types and constants for the radar sweep controller.
// Holds the FSM encoding, the timeout distance code and pulse arithmetic.
package radar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EMIT,
    S_STEP
  } state_e;

  localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;
  localparam logic [7:0]  ANGLE_MAX    = 8'd180;

  // 32-bit unsigned so 180 degrees never overflows the pulse width
  function automatic logic [31:0] pulse_cycles(
    input logic [7:0]  ang,
    input int unsigned pw_min,
    input int unsigned pw_per_deg
  );
    return pw_min + 32'(ang) * pw_per_deg;
  endfunction

endpackage

// File: rtl/radar_sweep_ctrl_if.sv
// Sample output handshake of the radar sweep controller.
// The controller is the master; the consumer drives sample_ready.
interface radar_sweep_ctrl_if;

  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  sample_angle;
  logic [15:0] sample_dist;
  logic        sample_timeout;

  modport master (
    output sample_valid,
    output sample_angle,
    output sample_dist,
    output sample_timeout,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_angle,
    input  sample_dist,
    input  sample_timeout,
    output sample_ready
  );

endinterface

// File: rtl/servo_pwm_gen.sv
// Free-running servo PWM frame generator.
// Pulse width is latched once per frame so it is never cut short.
module servo_pwm_gen
  import radar_pkg::*;
#(
  parameter int unsigned SERVO_PERIOD = 2_000_000,
  parameter int unsigned PW_MIN       = 100_000,
  parameter int unsigned PW_PER_DEG   = 556
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] angle,
  output logic       servo_pwm
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] thr_q, thr_d;
  logic        pwm_q, pwm_d;

  always_comb begin
    cnt_d = (cnt_q == SERVO_PERIOD - 1) ? '0 : cnt_q + 32'd1;
    thr_d = thr_q;
    if (cnt_d == '0) begin
      thr_d = pulse_cycles(angle, PW_MIN, PW_PER_DEG);
    end
    pwm_d = (cnt_d < thr_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      thr_q <= PW_MIN;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      thr_q <= thr_d;
      pwm_q <= pwm_d;
    end
  end

  assign servo_pwm = pwm_q;

endmodule

// File: rtl/radar_sweep_ctrl.sv
// Ping-pong servo sweep: settle, range, emit one sample per angle step.
// Samples are never aborted by start; only reset stops a sweep early.
module radar_sweep_ctrl
  import radar_pkg::*;
#(
  parameter int unsigned SERVO_PERIOD = 2_000_000,
  parameter int unsigned PW_MIN       = 100_000,
  parameter int unsigned PW_PER_DEG   = 556,
  parameter int unsigned STEP_DEG     = 10,
  parameter int unsigned SETTLE_CYC   = 25_000_000,
  parameter int unsigned MEAS_TIMEOUT = 6_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      done,
  input  logic [15:0]               distance,
  output logic                      enc,
  output logic                      servo_pwm,
  output logic [7:0]                angle,
  output logic                      busy,
  radar_sweep_ctrl_if.master        smp
);

  localparam logic [7:0] STEP = 8'(STEP_DEG);

  state_e      state_q, state_d;
  logic [7:0]  angle_q, angle_d;
  logic        up_q, up_d;
  logic [31:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [7:0]  sa_q, sa_d;
  logic [15:0] sd_q, sd_d;
  logic        st_q, st_d;
  logic        valid;
  logic [7:0]  next_ang;

  assign next_ang = up_q ? angle_q + STEP : angle_q - STEP;

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    up_d    = up_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    sa_d    = sa_q;
    sd_d    = sd_q;
    st_d    = st_q;
    enc     = 1'b0;
    valid   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_CYC - 1) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
          done_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_MEASURE: begin
        enc    = 1'b1;
        done_d = done;
        // a done edge takes priority over a simultaneous timeout
        if (done && !done_q) begin
          state_d = S_EMIT;
          sa_d    = angle_q;
          sd_d    = distance;
          st_d    = 1'b0;
        end else if (cnt_q == MEAS_TIMEOUT - 1) begin
          state_d = S_EMIT;
          sa_d    = angle_q;
          sd_d    = DIST_TIMEOUT;
          st_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_EMIT: begin
        valid = 1'b1;
        if (smp.sample_ready) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        angle_d = next_ang;
        if (next_ang == ANGLE_MAX) begin
          up_d = 1'b0;
        end else if (next_ang == 8'd0) begin
          up_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = start ? S_SETTLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      angle_q <= '0;
      up_q    <= 1'b1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sa_q    <= '0;
      sd_q    <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      up_q    <= up_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      sa_q    <= sa_d;
      sd_q    <= sd_d;
      st_q    <= st_d;
    end
  end

  assign angle              = angle_q;
  assign busy               = (state_q != S_IDLE);
  assign smp.sample_valid   = valid;
  assign smp.sample_angle   = sa_q;
  assign smp.sample_dist    = sd_q;
  assign smp.sample_timeout = st_q;

  servo_pwm_gen #(
    .SERVO_PERIOD (SERVO_PERIOD),
    .PW_MIN       (PW_MIN),
    .PW_PER_DEG   (PW_PER_DEG)
  ) u_pwm (
    .clk       (clk),
    .reset     (reset),
    .angle     (angle_q),
    .servo_pwm (servo_pwm)
  );

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Directed bench for radar_sweep_ctrl with shortened timing parameters.
// Timeline is counted in cycles from reset release.
module tb_radar_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic [15:0] distance;
  logic        enc;
  logic        servo_pwm;
  logic [7:0]  angle;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int n;
  int run = 0;
  int pulse_q[$];

  radar_sweep_ctrl_if smp ();

  radar_sweep_ctrl #(
    .SERVO_PERIOD (200),
    .PW_MIN       (10),
    .PW_PER_DEG   (1),
    .STEP_DEG     (90),
    .SETTLE_CYC   (20),
    .MEAS_TIMEOUT (50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .distance  (distance),
    .enc       (enc),
    .servo_pwm (servo_pwm),
    .angle     (angle),
    .busy      (busy),
    .smp       (smp.master)
  );

  always #5 clk = ~clk;

  // record each PWM high-time length since the last reset
  always @(posedge clk) begin
    if (reset) begin
      run = 0;
      pulse_q.delete();
    end else if (servo_pwm) begin
      run++;
    end else if (run > 0) begin
      pulse_q.push_back(run);
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_enc(output int cnt);
    cnt = 0;
    while (!enc && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!smp.sample_valid && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    done = 1'b0;
    distance = 16'd0;
    smp.sample_ready = 1'b1;
    repeat (3) tick();
    chk("rst_enc", 32'(enc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_angle", 32'(angle), 0);
    chk("rst_valid", 32'(smp.sample_valid), 0);
    chk("rst_sangle", 32'(smp.sample_angle), 0);
    chk("rst_sdist", 32'(smp.sample_dist), 0);
    chk("rst_stout", 32'(smp.sample_timeout), 0);
    chk("rst_pwm", 32'(servo_pwm), 0);

    // cycle 0: release reset and start sweeping
    reset = 1'b0;
    start = 1'b1;
    wait_enc(n);
    chk("settle_len", n, 21);
    chk("meas_busy", 32'(busy), 1);
    repeat (30) tick();
    done = 1'b1;
    distance = 16'd123;
    tick();
    chk("s1_valid", 32'(smp.sample_valid), 1);
    chk("s1_angle", 32'(smp.sample_angle), 0);
    chk("s1_dist", 32'(smp.sample_dist), 123);
    chk("s1_tout", 32'(smp.sample_timeout), 0);
    chk("s1_enc", 32'(enc), 0);
    done = 1'b0;
    tick();
    tick();
    chk("step_90", 32'(angle), 90);

    // second sample times out; consumer stalls for 100 cycles
    wait_enc(n);
    chk("settle_len2", n, 20);
    smp.sample_ready = 1'b0;
    wait_valid(n);
    chk("tout_lat", n, 50);
    chk("s2_angle", 32'(smp.sample_angle), 90);
    chk("s2_dist", 32'(smp.sample_dist), 32'h0000FFFF);
    chk("s2_tout", 32'(smp.sample_timeout), 1);
    chk("s2_enc", 32'(enc), 0);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("stall_hold",
          {7'd0, smp.sample_valid, smp.sample_angle,
           smp.sample_dist[7:0], smp.sample_timeout, angle[6:0]},
          {7'd0, 1'b1, 8'd90, 8'hFF, 1'b1, 7'd90});
    end
    smp.sample_ready = 1'b1;
    tick();
    chk("s2_taken", 32'(smp.sample_valid), 0);
    chk("s2_angle_hold", 32'(angle), 90);
    tick();
    chk("step_180", 32'(angle), 180);

    // third sample at 180 held past the next PWM frame start
    smp.sample_ready = 1'b0;
    wait_enc(n);
    chk("settle_len3", n, 20);
    repeat (30) tick();
    done = 1'b1;
    distance = 16'd456;
    tick();
    chk("s3_angle", 32'(smp.sample_angle), 180);
    chk("s3_dist", 32'(smp.sample_dist), 456);
    done = 1'b0;
    repeat (150) tick();
    smp.sample_ready = 1'b1;
    tick();
    tick();
    chk("pingpong_90", 32'(angle), 90);

    wait_enc(n);
    repeat (10) tick();
    done = 1'b1;
    distance = 16'd7;
    tick();
    chk("s4_angle", 32'(smp.sample_angle), 90);
    chk("s4_dist", 32'(smp.sample_dist), 7);
    done = 1'b0;
    tick();
    tick();
    chk("pingpong_0", 32'(angle), 0);

    // done edge coincides with timeout; start drops mid-measure
    wait_enc(n);
    start = 1'b0;
    repeat (49) tick();
    done = 1'b1;
    distance = 16'd5;
    tick();
    chk("tie_valid", 32'(smp.sample_valid), 1);
    chk("tie_angle", 32'(smp.sample_angle), 0);
    chk("tie_dist", 32'(smp.sample_dist), 5);
    chk("tie_tout", 32'(smp.sample_timeout), 0);
    done = 1'b0;
    tick();
    tick();
    chk("stop_busy", 32'(busy), 0);
    chk("stop_angle", 32'(angle), 90);
    repeat (80) tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_enc", 32'(enc), 0);

    chk("pulse_count", 32'(pulse_q.size() >= 3), 1);
    if (pulse_q.size() >= 3) begin
      chk("pulse_f1", pulse_q[1], 100);
      chk("pulse_f2", pulse_q[2], 190);
    end

    // reset while measuring aborts at once
    start = 1'b1;
    wait_enc(n);
    chk("restart", n, 21);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("mid_enc", 32'(enc), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_angle", 32'(angle), 0);
    chk("mid_valid", 32'(smp.sample_valid), 0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("post_valid", 32'(smp.sample_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/radar_sweep_ctrl.md
RADAR_SWEEP_CTRL -- requirements
Module: radar_sweep_ctrl

Interface
REQ-001 SHALL have parameter SERVO_PERIOD, default 2_000_000, servo PWM frame length in clk cycles (20 ms at 100 MHz).
REQ-002 SHALL have parameter PW_MIN, default 100_000, servo pulse width in cycles at 0 degrees.
REQ-003 SHALL have parameter PW_PER_DEG, default 556, added pulse cycles per degree.
REQ-004 SHALL have parameter STEP_DEG, default 10, sweep step in degrees; 180 is a multiple of STEP_DEG.
REQ-005 SHALL have parameter SETTLE_CYC, default 25_000_000, servo settle wait in cycles.
REQ-006 SHALL have parameter MEAS_TIMEOUT, default 6_000_000, max wait for a ranging result in cycles.
REQ-007 SHALL have ports, clock and reset first: clk in 1 system clock; reset in 1 synchronous active-high reset; start in 1 level run enable; done in 1 ranging-complete level from the ultrasonic stage; distance in 16 ranging result (cm); sample_ready in 1 consumer ready; enc out 1 ranging enable to the ultrasonic stage; servo_pwm out 1 servo drive; angle out 8 commanded angle 0..180; sample_valid out 1; sample_angle out 8; sample_dist out 16; sample_timeout out 1; busy out 1 (high in any state except IDLE).
REQ-008 SHALL be clocked by one clock, clk, with reset synchronous and active-high.

Function
REQ-009 SHALL implement states IDLE, SETTLE, MEASURE, EMIT, STEP.
REQ-010 IDLE: enc=0; on start=1 go to SETTLE with the settle counter cleared.
REQ-011 SETTLE: count SETTLE_CYC cycles, then go to MEASURE, clearing the timeout counter and done-edge history.
REQ-012 MEASURE: enc=1; a done rising edge (done=1, previous done=0) captures distance into sample_dist, clears sample_timeout, and goes to EMIT.
REQ-013 MEASURE: after MEAS_TIMEOUT cycles without a done rising edge, load sample_dist=16'hFFFF, set sample_timeout=1, and go to EMIT.
REQ-014 If a done edge and the timeout occur in the same cycle, the done edge wins.
REQ-015 EMIT: enc=0, sample_valid=1, sample_angle=angle; sample_* stay stable until sample_valid && sample_ready, then go to STEP.
REQ-016 STEP: angle += STEP_DEG when the sweep direction is up, else -= STEP_DEG; on reaching 180 set direction down, on reaching 0 set direction up (ping-pong, no repeat of an endpoint is skipped); then go to SETTLE if start=1, else IDLE.
REQ-017 start deasserting in SETTLE, MEASURE or EMIT has no effect until STEP completes (no aborted samples).
REQ-018 servo_pwm: free-running frame counter 0..SERVO_PERIOD-1; servo_pwm=1 while counter < PW_MIN + angle*PW_PER_DEG; the threshold is latched at frame start (counter=0) so an angle change never produces a truncated or extended pulse.
REQ-019 Pulse arithmetic SHALL be at least 22 bits wide, unsigned, with no overflow for angle<=180.
REQ-020 The PWM runs in all states, including IDLE (holds position).

Reset
REQ-021 On reset: state=IDLE, angle=0, direction=up, enc=0, servo_pwm=0, frame counter=0, latched threshold=PW_MIN, sample_valid=0, sample_angle=0, sample_dist=0, sample_timeout=0, busy=0, all counters=0.
REQ-022 Reset mid-sweep (any state) SHALL abort immediately; no sample_valid is emitted in the cycle after reset.

Structure
REQ-023 State encoding and the 16'hFFFF timeout code SHALL be in shared package radar_pkg.
REQ-024 Servo PWM generation SHALL be a sub-module servo_pwm_gen (inputs clk, reset, angle; output servo_pwm).

Verification (override SERVO_PERIOD=200, PW_MIN=10, PW_PER_DEG=1, SETTLE_CYC=20, MEAS_TIMEOUT=50, STEP_DEG=90)
REQ-025 Reset then start=1; model returns distance=123 with done 30 cycles after enc rises -> sample_valid with sample_angle=0, sample_dist=123, sample_timeout=0.
REQ-026 Done is never asserted -> sample_dist=16'hFFFF, sample_timeout=1 exactly 50 cycles after MEASURE entry; enc returns to 0.
REQ-027 Always-ready consumer, 5 samples -> sample_angle sequence 0, 90, 180, 90, 0.
REQ-028 sample_ready held low for 100 cycles in EMIT -> sample_* stable, no angle change; sample taken on the first ready cycle.
REQ-029 angle changes mid-frame -> the current pulse is unchanged; the next frame has high time 10+angle cycles (100 at angle 90).
REQ-030 reset=1 during MEASURE -> next cycle enc=0, busy=0, angle=0, sample_valid=0.
